// File: rtl/lap_store.sv
// lap_store: indexed lap-time storage with registered reads and an optional
// best-lap tracker; the tracker is built only when LAP_STORE_BEST_LAP_EN is defined.
module lap_store #(
  parameter int DEPTH = 10,
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sresult,
  input  logic [3:0]   widx,
  input  logic [W-1:0] time_in,
  input  logic         rview,
  input  logic [3:0]   ridx,
  input  logic         clear,
  output logic [W-1:0] rdata,
  output logic         rvalid,
  output logic [3:0]   count,
`ifdef LAP_STORE_BEST_LAP_EN
  output logic [3:0]   best_idx,
  output logic         best_valid,
  output logic         best_busy,
`endif
  output logic         full
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [AW-1:0] wa, ra;
  logic we, rhit;
  assign wa = widx[AW-1:0];
  assign ra = ridx[AW-1:0];
  assign we = sresult && !clear && widx < 4'(DEPTH);
  assign rhit = ridx < 4'(DEPTH) && vld[ra];
  assign full = count == 4'(DEPTH);
  always_ff @(posedge clk)
    if (we) mem[wa] <= time_in;
  // reads sample the array before this edge's write lands
  always_ff @(posedge clk) begin
    if (reset) begin
      vld <= '0;
      count <= '0;
      rdata <= '0;
      rvalid <= 1'b0;
    end else begin
      if (clear) begin
        vld <= '0;
        count <= '0;
      end else if (we) begin
        vld[wa] <= 1'b1;
        if (!vld[wa]) count <= count + 4'd1;
      end
      rvalid <= rview && !clear && rhit;
      if (rview) rdata <= (rhit && !clear) ? mem[ra] : '0;
    end
  end
`ifdef LAP_STORE_BEST_LAP_EN
  typedef enum logic {IDLE, SCAN} state_t;
  state_t state, state_nx;
  logic [3:0] sptr, cand_idx, nxt_idx;
  logic [W-1:0] cand_val, best_val, scan_val;
  logic cand_ok, nxt_ok, scan_hit, rescan, last;
  assign best_val = mem[best_idx[AW-1:0]];
  assign scan_val = mem[sptr[AW-1:0]];
  assign scan_hit = vld[sptr[AW-1:0]] && (!cand_ok || scan_val < cand_val);
  assign nxt_idx = scan_hit ? sptr : cand_idx;
  assign nxt_ok = cand_ok || vld[sptr[AW-1:0]];
  assign last = sptr == 4'(DEPTH - 1);
  // growing the current best can expose any other entry as the new minimum
  assign rescan = state == IDLE && we && best_valid && widx == best_idx && time_in > best_val;
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_nx;
  always_comb
    state_nx = clear ? IDLE : state == IDLE ? (rescan ? SCAN : IDLE) : (we || !last) ? SCAN : IDLE;
  always_comb
    best_busy = state == SCAN;
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      best_idx <= '0;
      best_valid <= 1'b0;
      sptr <= '0;
      cand_idx <= '0;
      cand_val <= '0;
      cand_ok <= 1'b0;
    end else if (we && (state == SCAN || rescan)) begin
      sptr <= '0;
      cand_ok <= 1'b0;
    end else if (state == SCAN) begin
      cand_idx <= nxt_idx;
      cand_val <= scan_hit ? scan_val : cand_val;
      cand_ok <= nxt_ok;
      sptr <= last ? '0 : sptr + 4'd1;
      if (last) begin
        best_idx <= nxt_idx;
        best_valid <= nxt_ok;
      end
    end else if (we && (!best_valid || time_in < best_val || (time_in == best_val && widx < best_idx))) begin
      best_idx <= widx;
      best_valid <= 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_lap_store.sv
// tb_lap_store: directed and random stimulus for lap_store against an array-based model.
module tb_lap_store;
  localparam int DEPTH = 10;
  localparam int W = 24;
  logic clk = 1'b0;
  logic reset, sresult, rview, clear, rvalid, full;
  logic [3:0] widx, ridx, count;
  logic [W-1:0] time_in, rdata;
`ifdef LAP_STORE_BEST_LAP_EN
  logic [3:0] best_idx;
  logic best_valid, best_busy;
`endif
  always #5 clk = ~clk;
  lap_store #(.DEPTH(DEPTH), .W(W)) dut (
    .clk(clk), .reset(reset), .sresult(sresult), .widx(widx), .time_in(time_in),
    .rview(rview), .ridx(ridx), .clear(clear), .rdata(rdata), .rvalid(rvalid),
    .count(count),
`ifdef LAP_STORE_BEST_LAP_EN
    .best_idx(best_idx), .best_valid(best_valid), .best_busy(best_busy),
`endif
    .full(full)
  );
  int checks = 0;
  int errors = 0;
  logic [W-1:0] m_mem [DEPTH];
  logic m_vld [DEPTH];
  int m_cnt = 0;
  int m_busy = 0;
  logic [W-1:0] m_rd = '0;
  logic m_rv = 1'b0;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  function automatic int amin();
    int b = -1;
    for (int i = 0; i < DEPTH; i++)
      if (m_vld[i] && (b < 0 || m_mem[i] < m_mem[b])) b = i;
    return b;
  endfunction
  task automatic step(logic s, logic [3:0] wi, logic [W-1:0] t, logic rv, logic [3:0] ri, logic cl, logic rs);
    int b0;
    logic hit, trig;
    sresult = s; widx = wi; time_in = t; rview = rv; ridx = ri; clear = cl; reset = rs;
    @(posedge clk);
    b0 = amin();
    if (rs) begin
      for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;
      m_cnt = 0; m_rd = '0; m_rv = 1'b0; m_busy = 0;
    end else begin
      hit = 1'b0;
      if (ri < DEPTH) hit = m_vld[ri] && !cl;
      if (rv) m_rd = hit ? m_mem[ri] : '0;
      m_rv = rv && hit;
      if (cl) begin
        for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;
        m_cnt = 0; m_busy = 0;
      end else if (s && wi < DEPTH) begin
        trig = m_busy > 0 || (b0 == int'(wi) && t > m_mem[wi]);
        m_busy = trig ? DEPTH : 0;
        m_mem[wi] = t;
        if (!m_vld[wi]) m_cnt++;
        m_vld[wi] = 1'b1;
      end else if (m_busy > 0) m_busy--;
    end
    #1;
    chk("count", 32'(count), 32'(m_cnt));
    chk("full", 32'(full), 32'(m_cnt == DEPTH));
    chk("rdata", 32'(rdata), 32'(m_rd));
    chk("rvalid", 32'(rvalid), 32'(m_rv));
`ifdef LAP_STORE_BEST_LAP_EN
    chk("best_busy", 32'(best_busy), 32'(m_busy > 0));
    if (m_busy == 0) begin
      chk("best_valid", 32'(best_valid), 32'(m_cnt > 0));
      if (m_cnt > 0) chk("best_idx", 32'(best_idx), 32'(amin()));
    end
`endif
  endtask
  initial begin
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("rst_count", 32'(count), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    step(1, 0, 24'h001234, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    chk("lap034_rdata", 32'(rdata), 32'h001234);
    chk("lap034_count", 32'(count), 1);
    for (int i = 1; i < DEPTH; i++) step(1, 4'(i), 24'(i) << 8, 0, 0, 0, 0);
    step(1, 4'd10, 24'h000001, 0, 0, 0, 0);
    chk("lap035_full", 32'(full), 1);
    chk("lap035_count", 32'(count), 10);
    step(0, 0, 0, 1, 4'd10, 0, 0);
    chk("lap035_rvalid", 32'(rvalid), 0);
    chk("lap035_rdata", 32'(rdata), 0);
    step(1, 3, 24'h000400, 0, 0, 0, 0);
    step(1, 3, 24'h000500, 1, 3, 0, 0);
    chk("lap037_old", 32'(rdata), 32'h000400);
    step(0, 0, 0, 1, 3, 0, 0);
    chk("lap037_new", 32'(rdata), 32'h000500);
    step(1, 5, 24'h000777, 0, 0, 1, 0);
    chk("lap036_count", 32'(count), 0);
    step(0, 0, 0, 1, 5, 0, 0);
    chk("lap036_rvalid", 32'(rvalid), 0);
`ifdef LAP_STORE_BEST_LAP_EN
    step(1, 0, 24'h000300, 0, 0, 0, 0);
    step(1, 1, 24'h000200, 0, 0, 0, 0);
    step(1, 2, 24'h000200, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("lap038_idx1", 32'(best_idx), 1);
    step(1, 1, 24'h000900, 0, 0, 0, 0);
    chk("lap038_busy", 32'(best_busy), 1);
    for (int i = 0; i < DEPTH - 1; i++) begin
      step(0, 0, 0, 0, 0, 0, 0);
      chk("lap038_busy_hold", 32'(best_busy), 1);
    end
    step(0, 0, 0, 0, 0, 0, 0);
    chk("lap038_done", 32'(best_busy), 0);
    chk("lap038_idx2", 32'(best_idx), 2);
    step(1, 2, 24'h000a00, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 1);
    chk("lap039_busy", 32'(best_busy), 0);
    chk("lap039_bvalid", 32'(best_valid), 0);
    chk("lap039_bidx", 32'(best_idx), 0);
`else
    step(0, 0, 0, 1, 0, 0, 1);
`endif
    chk("lap039_count", 32'(count), 0);
    chk("lap039_rdata", 32'(rdata), 0);
    for (int n = 0; n < 3000; n++)
      step($urandom_range(0, 9) < 4, 4'($urandom_range(0, 11)), 24'($urandom_range(0, 7)) << 8,
           $urandom_range(0, 9) < 6, 4'($urandom_range(0, 11)), $urandom_range(0, 99) < 2,
           $urandom_range(0, 199) == 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lap_store.md
LAP_STORE -- requirements
Module: lap_store

Interface
REQ-001 SHALL have parameter DEPTH, default 10, number of lap entries (2..15).
REQ-002 SHALL have parameter W, default 24, entry width: packed BCD mm:ss:hh, 6 digits.
REQ-003 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have port sresult, input, 1, store strobe, one-cycle pulse from the stopwatch control FSM.
REQ-006 SHALL have port widx, input, 4, write index, sampled with sresult.
REQ-007 SHALL have port time_in, input, W, current BCD time, sampled with sresult.
REQ-008 SHALL have port rview, input, 1, read-view enable.
REQ-009 SHALL have port ridx, input, 4, read index, sampled while rview is high.
REQ-010 SHALL have port clear, input, 1, synchronous clear of all entries.
REQ-011 SHALL have port rdata, output, W, entry selected by ridx.
REQ-012 SHALL have port rvalid, output, 1, rdata holds a stored entry.
REQ-013 SHALL have port count, output, 4, number of valid entries.
REQ-014 SHALL have port full, output, 1, count == DEPTH.
REQ-015 SHALL have ports best_idx (output, 4), best_valid (output, 1) and best_busy (output, 1) when BEST_LAP_EN is defined.

Function
REQ-016 SHALL write time_in into entry widx on the clk edge where sresult=1, widx<DEPTH and clear=0, and set that entry's valid bit.
REQ-017 SHALL ignore sresult when widx>=DEPTH; no state change.
REQ-018 SHALL overwrite an already-valid entry without changing count; writing an empty entry increments count by 1.
REQ-019 SHALL register reads with one-cycle latency: when rview=1 at edge N, rdata/rvalid SHALL reflect entry ridx after edge N+1.
REQ-020 SHALL return rdata=0 and rvalid=0 for ridx>=DEPTH or an invalid entry.
REQ-021 SHALL hold rdata and force rvalid=0 while rview=0.
REQ-022 SHALL return the old entry value when a read and a write to the same index occur in the same cycle (read-before-write).
REQ-023 SHALL, on clear=1, invalidate all entries, set count=0 and rvalid=0, and drop any concurrent sresult (clear wins).
REQ-024 SHALL never let count exceed DEPTH; full SHALL be combinational from count.

Reset
REQ-025 SHALL, with reset=1 at a clk edge, set rdata=0, rvalid=0, count=0, full=0, all valid bits=0, best_idx=0, best_valid=0, best_busy=0, and best FSM=IDLE.
REQ-026 SHALL give reset priority over clear, sresult and rview; reset mid-scan SHALL abort the scan.
REQ-027 SHALL NOT require the entry storage contents to be reset; only valid bits are reset.

Configuration
REQ-028 SHALL compile best-lap tracking only when the macro LAP_STORE_BEST_LAP_EN is defined; without it, the best_* ports and logic SHALL be absent.
REQ-029 SHALL, with the macro defined, compare entries as unsigned W-bit values (packed BCD preserves order); the smallest valid entry wins, and the lowest index wins on ties.
REQ-030 SHALL, on a write to an index other than best_idx, update best_idx to the written index after one cycle if time_in < best time or best_valid=0.
REQ-031 SHALL, on a write to best_idx with a larger value, enter state SCAN: set best_busy=1 and visit indices 0..DEPTH-1, one per cycle; after DEPTH cycles return to IDLE with best_busy=0 and best_idx/best_valid reflecting the minimum.
REQ-032 SHALL restart the scan from index 0 if any accepted write occurs during SCAN.
REQ-033 SHALL set best_valid=0 on clear and SHALL keep best_valid=0 while count==0.

Verification
REQ-034 Store 00:12:34 at widx=0, then rview=1 with ridx=0 -> rdata=0x001234 and rvalid=1 one cycle later; count=1.
REQ-035 Store entries at widx 0..9, then store at widx=10 -> full=1, count=10, index 10 ignored; ridx=10 -> rdata=0, rvalid=0.
REQ-036 Assert sresult and clear in the same cycle -> count=0, entry not stored; rview on that index -> rvalid=0.
REQ-037 Write 0x000500 at idx 3 and read idx 3 in the same cycle, where idx 3 previously held 0x000400 -> rdata=0x000400; the next read returns 0x000500.
REQ-038 (BEST_LAP_EN) Store 0x000300@0, 0x000200@1, 0x000200@2 -> best_idx=1; overwrite idx 1 with 0x000900 -> best_busy=1 for 10 cycles, then best_idx=2.
REQ-039 Assert reset during a scan -> all outputs 0 on the next edge; best_busy=0.
